// File: rtl/clksel_ctrl.sv
// Clock-select sequencer: switches hsclk/lsclk around host bus cycles and stages divider config.
// Optional macro CLKSEL_LINGER_EN enables the SLOW-state linger counter (cfg[7:4]).
module clksel_ctrl (
    input  logic       hsclk_in,
    input  logic       rst,
    input  logic       lsclk_in,
    input  logic       cycle_start,
    input  logic       host_req,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_wdata,
    output logic [7:0] cfg_rdata,
    output logic       hsclk_sel,
    output logic [1:0] hsclk_div_sel,
    output logic [1:0] cpuclk_div_sel,
    output logic       busy
);

    typedef enum logic [1:0] {
        StFast,
        StToSlow,
        StSlow,
        StToFast
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] settle_q, settle_d;
    logic       pending_q, pending_d;
    logic       sync1_q, sync2_q, sync3_q;
    logic [3:0] staged_q, applied_q;
    logic [3:0] linger_q;
    logic [3:0] linger_field;
    logic       ls_fall;
    logic       host_cyc;

    // lsclk_in is asynchronous; sync3_q is a spare delayed copy of the synchronised level.
    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= lsclk_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign ls_fall  = sync2_q & ~sync1_q;
    assign host_cyc = cycle_start & host_req;

`ifdef CLKSEL_LINGER_EN
    logic [3:0] cfg_hi_q;
    logic [3:0] linger_d;
    logic       unused_sync;

    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            cfg_hi_q <= 4'h0;
        end else if (cfg_wr) begin
            cfg_hi_q <= cfg_wdata[7:4];
        end
    end

    assign linger_field = cfg_hi_q;

    // Reload on SLOW entry and on every host cycle; a coincident host cycle beats ls_fall.
    always_comb begin
        linger_d = linger_q;
        if (state_q == StToSlow && state_d == StSlow) begin
            linger_d = cfg_hi_q;
        end else if (state_q == StSlow) begin
            if (host_cyc) begin
                linger_d = cfg_hi_q;
            end else if (ls_fall && linger_q != 4'h0) begin
                linger_d = linger_q - 4'd1;
            end
        end
    end

    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            linger_q <= 4'h0;
        end else begin
            linger_q <= linger_d;
        end
    end

    assign unused_sync = sync3_q;
`else
    logic unused_bits;

    assign linger_field = 4'h0;
    assign linger_q     = 4'h0;
    assign unused_bits  = ^{sync3_q, cfg_wdata[7:4]};
`endif

    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            state_q   <= StSlow;
            settle_q  <= 2'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        pending_d = pending_q;
        unique case (state_q)
            StFast: begin
                if (host_cyc || pending_q) begin
                    state_d   = StToSlow;
                    settle_d  = 2'd0;
                    pending_d = 1'b0;
                end
            end
            StToSlow: begin
                if (settle_q == 2'd2) begin
                    state_d  = StSlow;
                    settle_d = 2'd0;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            StSlow: begin
                if (ls_fall && !host_cyc && linger_q == 4'h0) begin
                    state_d  = StToFast;
                    settle_d = 2'd0;
                end
            end
            StToFast: begin
                // A host cycle arriving mid-switch is replayed once FAST is reached.
                if (host_cyc) begin
                    pending_d = 1'b1;
                end
                if (settle_q == 2'd2) begin
                    state_d  = StFast;
                    settle_d = 2'd0;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            default: begin
                state_d = StSlow;
            end
        endcase
    end

    // Divider bits only reach the clock controller while it runs from the slow clock.
    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            staged_q  <= 4'h0;
            applied_q <= 4'h0;
        end else begin
            if (cfg_wr) begin
                staged_q <= cfg_wdata[3:0];
            end
            if (state_q == StSlow) begin
                applied_q <= staged_q;
            end
        end
    end

    assign hsclk_sel      = (state_q == StFast) || (state_q == StToFast);
    assign busy           = (state_q == StToSlow) || (state_q == StToFast);
    assign hsclk_div_sel  = applied_q[1:0];
    assign cpuclk_div_sel = applied_q[3:2];
    assign cfg_rdata      = {linger_field, applied_q};

endmodule

// File: tb/tb_clksel_ctrl.sv
// Directed self-checking bench for clksel_ctrl; expectations follow CLKSEL_LINGER_EN when defined.
module tb_clksel_ctrl;

    logic       hsclk_in;
    logic       rst;
    logic       lsclk_in;
    logic       cycle_start;
    logic       host_req;
    logic       cfg_wr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       hsclk_sel;
    logic [1:0] hsclk_div_sel;
    logic [1:0] cpuclk_div_sel;
    logic       busy;

    int checks;
    int errors;

    clksel_ctrl dut (
        .hsclk_in      (hsclk_in),
        .rst           (rst),
        .lsclk_in      (lsclk_in),
        .cycle_start   (cycle_start),
        .host_req      (host_req),
        .cfg_wr        (cfg_wr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .hsclk_sel     (hsclk_sel),
        .hsclk_div_sel (hsclk_div_sel),
        .cpuclk_div_sel(cpuclk_div_sel),
        .busy          (busy)
    );

    initial begin
        hsclk_in = 1'b0;
        forever #5 hsclk_in = ~hsclk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {hsclk_sel, busy}: FAST=10, TO_FAST=11, SLOW=00, TO_SLOW=01
    task automatic tick();
        @(posedge hsclk_in);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic host_cycle();
        cycle_start = 1'b1;
        host_req    = 1'b1;
        tick();
        cycle_start = 1'b0;
        host_req    = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] data);
        cfg_wr    = 1'b1;
        cfg_wdata = data;
        tick();
        cfg_wr    = 1'b0;
        cfg_wdata = 8'h00;
    endtask

    // Leaves ls_fall asserted in the current cycle; the next edge consumes it.
    task automatic ls_fall_pulse();
        lsclk_in = 1'b1;
        repeat (4) tick();
        lsclk_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checks++;
        if ({hsclk_sel, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got %b want 00", {hsclk_sel, busy});
        end
        checks++;
        if (cfg_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 00", cfg_rdata);
        end
        checks++;
        if ({hsclk_div_sel, cpuclk_div_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_div: got %b want 0000", {hsclk_div_sel, cpuclk_div_sel});
        end
    endtask

    task automatic test_first_fall();
        lsclk_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({hsclk_sel, busy} !== 2'b00) begin
                errors++;
                $display("FAIL first_fall_wait[%0d]: got %b want 00", i, {hsclk_sel, busy});
            end
        end
        lsclk_in = 1'b0;
        tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b00) begin
            errors++;
            $display("FAIL first_fall_sync: got %b want 00", {hsclk_sel, busy});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({hsclk_sel, busy} !== 2'b11) begin
                errors++;
                $display("FAIL first_fall_busy[%0d]: got %b want 11", i, {hsclk_sel, busy});
            end
        end
        tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b10) begin
            errors++;
            $display("FAIL first_fall_fast: got %b want 10", {hsclk_sel, busy});
        end
    endtask

    task automatic test_to_slow();
        host_cycle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({hsclk_sel, busy} !== 2'b01) begin
                errors++;
                $display("FAIL to_slow_busy[%0d]: got %b want 01", i, {hsclk_sel, busy});
            end
            tick();
        end
        checks++;
        if ({hsclk_sel, busy} !== 2'b00) begin
            errors++;
            $display("FAIL to_slow_slow: got %b want 00", {hsclk_sel, busy});
        end
        ls_fall_pulse();
        tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b11) begin
            errors++;
            $display("FAIL to_slow_return: got %b want 11", {hsclk_sel, busy});
        end
        settle();
        checks++;
        if ({hsclk_sel, busy} !== 2'b10) begin
            errors++;
            $display("FAIL to_slow_fast: got %b want 10", {hsclk_sel, busy});
        end
    endtask

    task automatic test_host_ignore();
        host_req = 1'b1;
        tick();
        host_req = 1'b0;
        checks++;
        if ({hsclk_sel, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ignore_req_only: got %b want 10", {hsclk_sel, busy});
        end
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        checks++;
        if ({hsclk_sel, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ignore_local_cycle: got %b want 10", {hsclk_sel, busy});
        end
    endtask

    task automatic test_linger();
        logic [7:0] exp_rdata;
`ifdef CLKSEL_LINGER_EN
        exp_rdata = 8'h30;
`else
        exp_rdata = 8'h00;
`endif
        cfg_write(8'h30);
        checks++;
        if (cfg_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL linger_rdata: got %h want %h", cfg_rdata, exp_rdata);
        end
        host_cycle();
        settle();
        host_cycle();
        checks++;
        if ({hsclk_sel, busy} !== 2'b00) begin
            errors++;
            $display("FAIL linger_slow: got %b want 00", {hsclk_sel, busy});
        end
`ifdef CLKSEL_LINGER_EN
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] exp_st;
            exp_st = (i == 4) ? 2'b11 : 2'b00;
            ls_fall_pulse();
            tick();
            checks++;
            if ({hsclk_sel, busy} !== exp_st) begin
                errors++;
                $display("FAIL linger_fall[%0d]: got %b want %b", i, {hsclk_sel, busy}, exp_st);
            end
        end
`else
        ls_fall_pulse();
        tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b11) begin
            errors++;
            $display("FAIL linger_off_fall: got %b want 11", {hsclk_sel, busy});
        end
`endif
        settle();
    endtask

    task automatic test_host_wins();
        cfg_write(8'h00);
        host_cycle();
        settle();
        ls_fall_pulse();
        cycle_start = 1'b1;
        host_req    = 1'b1;
        tick();
        cycle_start = 1'b0;
        host_req    = 1'b0;
        checks++;
        if ({hsclk_sel, busy} !== 2'b00) begin
            errors++;
            $display("FAIL host_wins: got %b want 00", {hsclk_sel, busy});
        end
        ls_fall_pulse();
        tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b11) begin
            errors++;
            $display("FAIL host_wins_next_fall: got %b want 11", {hsclk_sel, busy});
        end
        settle();
    endtask

    task automatic test_cfg_stage();
        cfg_write(8'h02);
        cfg_write(8'h0D);
        checks++;
        if ({hsclk_div_sel, cpuclk_div_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL stage_fast_div: got %b want 0000", {hsclk_div_sel, cpuclk_div_sel});
        end
        checks++;
        if (cfg_rdata !== 8'h00) begin
            errors++;
            $display("FAIL stage_fast_rdata: got %h want 00", cfg_rdata);
        end
        host_cycle();
        checks++;
        if ({hsclk_div_sel, cpuclk_div_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL stage_to_slow_div: got %b want 0000", {hsclk_div_sel, cpuclk_div_sel});
        end
        settle();
        tick();
        checks++;
        if (hsclk_div_sel !== 2'b01 || cpuclk_div_sel !== 2'b11) begin
            errors++;
            $display("FAIL stage_slow_div: got %b/%b want 01/11", hsclk_div_sel, cpuclk_div_sel);
        end
        checks++;
        if (cfg_rdata !== 8'h0D) begin
            errors++;
            $display("FAIL stage_slow_rdata: got %h want 0d", cfg_rdata);
        end
        ls_fall_pulse();
        tick();
        settle();
        checks++;
        if ({hsclk_sel, busy, hsclk_div_sel, cpuclk_div_sel} !== 6'b10_01_11) begin
            errors++;
            $display("FAIL stage_hold_fast: got %b want 100111",
                     {hsclk_sel, busy, hsclk_div_sel, cpuclk_div_sel});
        end
    endtask

    task automatic test_pending();
        host_cycle();
        settle();
        ls_fall_pulse();
        tick();
        host_cycle();
        checks++;
        if ({hsclk_sel, busy} !== 2'b11) begin
            errors++;
            $display("FAIL pend_to_fast: got %b want 11", {hsclk_sel, busy});
        end
        tick();
        tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b10) begin
            errors++;
            $display("FAIL pend_fast_once: got %b want 10", {hsclk_sel, busy});
        end
        tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b01) begin
            errors++;
            $display("FAIL pend_to_slow: got %b want 01", {hsclk_sel, busy});
        end
        settle();
        ls_fall_pulse();
        tick();
        settle();
        repeat (2) tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b10) begin
            errors++;
            $display("FAIL pend_cleared: got %b want 10", {hsclk_sel, busy});
        end
    endtask

    task automatic test_reset_mid();
        cfg_write(8'h06);
        host_cycle();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({hsclk_sel, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_state: got %b want 00", {hsclk_sel, busy});
        end
        checks++;
        if (cfg_rdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_rdata: got %h want 00", cfg_rdata);
        end
        repeat (3) tick();
        checks++;
        if ({hsclk_div_sel, cpuclk_div_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_staged: got %b want 0000", {hsclk_div_sel, cpuclk_div_sel});
        end
        ls_fall_pulse();
        tick();
        checks++;
        if ({hsclk_sel, busy} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_first_fall: got %b want 11", {hsclk_sel, busy});
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        lsclk_in    = 1'b0;
        cycle_start = 1'b0;
        host_req    = 1'b0;
        cfg_wr      = 1'b0;
        cfg_wdata   = 8'h00;
        test_reset();
        test_first_fall();
        test_to_slow();
        test_host_ignore();
        test_linger();
        test_host_wins();
        test_cfg_stage();
        test_pending();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
